stack_arbiter: RTL and testbench

Two-port arbiter and sequencer for the on-chip LIFO stack: owns the stack memory and pointer, accepts push/pop requests from two independent requesters (A, B), grants them round-robin, and executes one stack operation at a time. Sits between the top-level I/O decode and the stack storage, replacing direct push/pop strobes with a req/ack handshake, full/empty status and error reporting.

---
 rtl/stack_arbiter_if.sv | 31 +++
 rtl/stack_arbiter.sv | 118 +++++++++++
 tb/tb_stack_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// Request/acknowledge bus between the two stack requesters and stack_arbiter.
// The arbiter uses the slave modport; the requesters use the master modport.
interface stack_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             a_req;
    logic             a_op;
    logic [WIDTH-1:0] a_wdata;
    logic             a_ack;
    logic             b_req;
    logic             b_op;
    logic [WIDTH-1:0] b_wdata;
    logic             b_ack;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             done;

    modport master (
        output a_req, a_op, a_wdata, b_req, b_op, b_wdata,
        input  a_ack, b_ack, rdata, err, count, full, empty, done
    );

    modport slave (
        input  a_req, a_op, a_wdata, b_req, b_op, b_wdata,
        output a_ack, b_ack, rdata, err, count, full, empty, done
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin two-port arbiter in front of a LIFO stack; one push/pop per
// IDLE -> EXEC -> RESP pass, with a one-cycle ack to the granted requester.
module stack_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic            clk,
    input logic            rst,
    stack_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;     // 1: B was granted most recently
    logic             id_q, id_d;         // 1: current operation belongs to B
    logic             op_q, op_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic          mem_we;
    logic          is_full;
    logic          is_empty;
    logic          grant_b;
    logic [AW-1:0] rd_addr;

    assign is_full  = (count_q == (AW+1)'(DEPTH));
    assign is_empty = (count_q == '0);
    assign rd_addr  = AW'(count_q - 1'b1);
    assign grant_b  = bus.b_req && (!bus.a_req || !last_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        count_d = count_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    id_d    = grant_b;
                    last_d  = grant_b;
                    op_d    = grant_b ? bus.b_op : bus.a_op;
                    wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                rdata_d = '0;
                if (op_q) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                        err_d   = 1'b0;
                    end
                end else if (is_empty) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d = mem_q[rd_addr];
                    count_d = count_q - 1'b1;
                    err_d   = 1'b0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; entries at or above count are never read, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= wdata_q;
        end
    end

    assign bus.a_ack = (state_q == RESP) && !id_q;
    assign bus.b_ack = (state_q == RESP) && id_q;
    assign bus.rdata = (state_q == RESP) ? rdata_q : '0;
    assign bus.err   = (state_q == RESP) && err_q;
    assign bus.count = count_q;
    assign bus.full  = is_full;
    assign bus.empty = is_empty;
    assign bus.done  = (state_q == IDLE);
endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: table-driven single ops, overflow,
// underflow, contention and reset corner cases against a response scoreboard.
module tb_stack_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;

    stack_arbiter_if #(.WIDTH(8), .AW(4)) bus ();

    stack_arbiter #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       id;
        logic [7:0] rdata;
        logic       err;
        logic [4:0] count;
    } exp_t;

    typedef struct {
        bit         is_b;
        bit         op;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
        logic [4:0] exp_count;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic expect_rsp(input bit id, input logic [7:0] rd, input bit e, input logic [4:0] c);
        exp_t x;
        x.id = id; x.rdata = rd; x.err = e; x.count = c;
        sb.push_back(x);
    endtask

    // Waits (bounded) for the given requester's ack; n = negedges waited.
    task automatic wait_ack(input bit is_b, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_b ? bus.b_ack : bus.a_ack) && n < 20);
    endtask

    // Single isolated operation, started from IDLE at a negedge.
    task automatic do_op(input vec_t v);
        int n;
        expect_rsp(v.is_b, v.exp_rdata, v.exp_err, v.exp_count);
        if (v.is_b) begin
            bus.b_req = 1'b1; bus.b_op = v.op; bus.b_wdata = v.wdata;
        end else begin
            bus.a_req = 1'b1; bus.a_op = v.op; bus.a_wdata = v.wdata;
        end
        wait_ack(v.is_b, n);
        check("op_latency", n, 2);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit b, bit op, logic [7:0] wd, logic [7:0] rd, bit e, logic [4:0] c);
        vec_t v;
        v.is_b = b; v.op = op; v.wdata = wd; v.exp_rdata = rd; v.exp_err = e; v.exp_count = c;
        return v;
    endfunction

    // Response monitor: every ack is matched against the scoreboard head.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (bus.a_ack || bus.b_ack) begin
                check("ack_onehot", 32'(bus.a_ack & bus.b_ack), 0);
                check("done_in_resp", bus.done, 0);
                check("sb_nonempty_at_ack", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("ack_id", bus.b_ack, mon_e.id);
                    check("rdata", bus.rdata, mon_e.rdata);
                    check("err", bus.err, mon_e.err);
                    check("count", bus.count, mon_e.count);
                    check("full", bus.full, 32'(mon_e.count == 5'd16));
                    check("empty", bus.empty, 32'(mon_e.count == 5'd0));
                end
            end else begin
                check("noack_rdata", bus.rdata, 0);
                check("noack_err", bus.err, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        cyc = 0; n_pass = 0; n_total = 0;
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_wdata = '0;

        vecs[0] = mk(1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 5'd1);
        vecs[1] = mk(1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 5'd2);
        vecs[2] = mk(1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 5'd1);
        vecs[3] = mk(1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 5'd0);
        vecs[4] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 5'd0);
        vecs[5] = mk(1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 5'd1);
        vecs[6] = mk(1'b0, 1'b0, 8'h00, 8'h33, 1'b0, 5'd0);

        // Reset held two cycles with both requests high.
        @(negedge clk);
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_a_ack", bus.a_ack, 0);
        check("rst_b_ack", bus.b_ack, 0);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_done", bus.done, 1);
        rst = 1'b0;
        expect_rsp(1'b0, 8'h00, 1'b1, 5'd0);
        expect_rsp(1'b1, 8'h00, 1'b1, 5'd0);
        wait_ack(1'b0, n);
        check("first_ack_to_a_latency", n, 2);
        bus.a_req = 1'b0;
        wait_ack(1'b1, n);
        check("b_after_a_interval", n, 3);
        bus.b_req = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i]);

        // Overflow: fill, reject one extra push, pop the top, drain.
        for (int i = 0; i < 16; i++) do_op(mk(1'b0, 1'b1, 8'(i), 8'h00, 1'b0, 5'(i + 1)));
        check("full_after_fill", bus.full, 1);
        check("count_after_fill", bus.count, 16);
        do_op(mk(1'b0, 1'b1, 8'hAA, 8'h00, 1'b1, 5'd16));
        do_op(mk(1'b0, 1'b0, 8'h00, 8'h0F, 1'b0, 5'd15));
        for (int i = 14; i >= 0; i--) do_op(mk(1'b0, 1'b0, 8'h00, 8'(i), 1'b0, 5'(i)));

        // Reset during EXEC of a push aborts it with no ack.
        do_op(mk(1'b0, 1'b1, 8'h66, 8'h00, 1'b0, 5'd1));
        bus.a_req = 1'b1; bus.a_op = 1'b1; bus.a_wdata = 8'h55;
        @(negedge clk);
        check("done_low_in_exec", bus.done, 0);
        rst = 1'b1;
        bus.a_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midop_rst_count", bus.count, 0);
        check("midop_rst_empty", bus.empty, 1);
        repeat (3) @(negedge clk);
        do_op(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 5'd0));

        // Contention: both push continuously, then both pop everything.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_rsp(1'b0, 8'h00, 1'b0, 5'(2 * i + 1));
            expect_rsp(1'b1, 8'h00, 1'b0, 5'(2 * i + 2));
        end
        bus.a_req = 1'b1; bus.a_op = 1'b1; bus.a_wdata = 8'hA0;
        bus.b_req = 1'b1; bus.b_op = 1'b1; bus.b_wdata = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, n);
            check("push_a_interval", n, (i == 0) ? 2 : 3);
            if (i < 3) bus.a_wdata = 8'hA0 + 8'(i + 1);
            else bus.a_req = 1'b0;
            wait_ack(1'b1, n);
            check("push_b_interval", n, 3);
            if (i < 3) bus.b_wdata = 8'hB0 + 8'(i + 1);
            else bus.b_req = 1'b0;
        end
        @(negedge clk);
        for (int i = 3; i >= 0; i--) begin
            expect_rsp(1'b0, 8'hB0 + 8'(i), 1'b0, 5'(2 * i + 1));
            expect_rsp(1'b1, 8'hA0 + 8'(i), 1'b0, 5'(2 * i));
        end
        bus.a_req = 1'b1; bus.a_op = 1'b0;
        bus.b_req = 1'b1; bus.b_op = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, n);
            check("pop_a_interval", n, (i == 0) ? 2 : 3);
            if (i == 3) bus.a_req = 1'b0;
            wait_ack(1'b1, n);
            check("pop_b_interval", n, 3);
            if (i == 3) bus.b_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("final_empty", bus.empty, 1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
